// File: rtl/oam_dma.sv
`timescale 1ns/1ps
// oam_dma: sprite DMA copying a 256-byte CPU page into the video block's OAMDATA register while the CPU is halted
module oam_dma #(
    parameter logic [15:0] P_trigger_addr = 16'h4014,
    parameter logic [2:0]  P_ppu_reg      = 3'd4
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_tick,
    input  logic [15:0] I_cpu_addr,
    input  logic        I_cpu_wren,
    input  logic [7:0]  I_cpu_data,
    output logic        O_cpu_halt,
    output logic        O_busy,
    output logic [15:0] O_bus_addr,
    output logic        O_bus_rden,
    input  logic [7:0]  I_bus_data,
    output logic [2:0]  O_ppu_addr,
    output logic        O_ppu_wren,
    output logic [7:0]  O_ppu_data
);
    typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;
    state_t     r_state, w_next;
    logic [7:0] r_page, r_index, r_latch;
    logic       r_parity, r_capture;
    logic       w_trigger, w_rd, w_wr;
    assign w_trigger = I_tick & I_cpu_wren & (I_cpu_addr == P_trigger_addr) & (r_state == S_IDLE);
    assign w_rd      = I_tick & ~I_reset & (r_state == S_READ);
    assign w_wr      = I_tick & ~I_reset & (r_state == S_WRITE);
    // state register
    always_ff @(posedge I_clock) begin
        if (I_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end
    // next state: HALT picks ALIGN when the following tick would be odd so reads land on even ticks
    always_comb begin
        w_next = r_state;
        if (I_tick) begin
            case (r_state)
                S_IDLE:  w_next = w_trigger ? S_HALT : S_IDLE;
                S_HALT:  w_next = r_parity ? S_READ : S_ALIGN;
                S_ALIGN: w_next = S_READ;
                S_READ:  w_next = S_WRITE;
                S_WRITE: w_next = (r_index == 8'hFF) ? S_IDLE : S_READ;
                default: w_next = S_IDLE;
            endcase
        end
    end
    // outputs: strobes only on ticks; read data bypasses the latch when the write tick is the capture clock
    always_comb begin
        O_cpu_halt = r_state != S_IDLE;
        O_busy     = r_state != S_IDLE;
        O_bus_addr = {r_page, r_index};
        O_bus_rden = w_rd;
        O_ppu_addr = P_ppu_reg;
        O_ppu_wren = w_wr;
        O_ppu_data = (r_capture && w_wr) ? I_bus_data : r_latch;
    end
    // datapath: parity, page/index and the read-data latch
    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            r_page    <= 8'h00;
            r_index   <= 8'h00;
            r_latch   <= 8'h00;
            r_parity  <= 1'b0;
            r_capture <= 1'b0;
        end else begin
            r_capture <= w_rd;
            if (r_capture) r_latch <= I_bus_data;
            if (I_tick) begin
                r_parity <= ~r_parity;
                if (w_trigger) begin
                    r_page  <= I_cpu_data;
                    r_index <= 8'h00;
                end
                if (r_state == S_WRITE) r_index <= r_index + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_oam_dma.sv
`timescale 1ns/1ps
// tb_oam_dma: directed vectors and multi-cycle transfer sequences for oam_dma
module tb_oam_dma;
    logic        I_clock, I_reset, I_tick, I_cpu_wren;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_data, I_bus_data;
    logic        O_cpu_halt, O_busy, O_bus_rden, O_ppu_wren;
    logic [15:0] O_bus_addr;
    logic [2:0]  O_ppu_addr;
    logic [7:0]  O_ppu_data;

    oam_dma dut (
        .I_clock(I_clock), .I_reset(I_reset), .I_tick(I_tick),
        .I_cpu_addr(I_cpu_addr), .I_cpu_wren(I_cpu_wren), .I_cpu_data(I_cpu_data),
        .O_cpu_halt(O_cpu_halt), .O_busy(O_busy), .O_bus_addr(O_bus_addr), .O_bus_rden(O_bus_rden),
        .I_bus_data(I_bus_data), .O_ppu_addr(O_ppu_addr), .O_ppu_wren(O_ppu_wren), .O_ppu_data(O_ppu_data)
    );

    initial I_clock = 1'b0;
    always #5 I_clock = ~I_clock;

    // memory model: byte = low address byte ^ 5A, valid the clock after a read strobe, junk otherwise
    always @(posedge I_clock) I_bus_data <= O_bus_rden ? (O_bus_addr[7:0] ^ 8'h5A) : 8'hEE;

    typedef struct {
        logic        t;
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
        logic        busy;
    } vec_t;
    vec_t vt[5];

    int n_cmp = 0, n_err = 0;
    int rd_cnt, wr_cnt, halt_ticks;
    logic        tb_par;
    logic [7:0]  cur_page;
    logic [15:0] last_rd;
    logic        s_halt, s_busy, s_rden, s_wren;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    logic [2:0]  s_reg;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // one clock: drive tick, sample/check outputs at negedge, advance past the edge
    task automatic cyc(input logic t);
        I_tick = t;
        @(negedge I_clock);
        s_halt = O_cpu_halt; s_busy = O_busy; s_rden = O_bus_rden; s_wren = O_ppu_wren;
        s_addr = O_bus_addr; s_data = O_ppu_data; s_reg = O_ppu_addr;
        if (!t) chk("strobe_no_tick", {14'd0, O_bus_rden, O_ppu_wren}, 16'd0);
        if (O_bus_rden) begin
            chk("rd_addr", O_bus_addr, {cur_page, rd_cnt[7:0]});
            if (rd_cnt == 0) chk("first_rd_parity", {15'd0, tb_par}, 16'd0);
            last_rd = O_bus_addr;
            rd_cnt++;
        end
        if (O_ppu_wren) begin
            chk("wr_data", {8'd0, O_ppu_data}, {8'd0, wr_cnt[7:0] ^ 8'h5A});
            chk("wr_reg", {13'd0, O_ppu_addr}, 16'd4);
            chk("wr_after_rd", {15'd0, wr_cnt < rd_cnt}, 16'd1);
            wr_cnt++;
        end
        if (t && O_cpu_halt) halt_ticks++;
        @(posedge I_clock); #1;
        if (t) tb_par = ~tb_par;
        I_cpu_wren = 1'b0;
    endtask

    task automatic rst();
        I_reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        I_reset = 1'b0;
        tb_par = 1'b0;
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_halt"}, {15'd0, s_halt}, 16'd0);
        chk({n, "_busy"}, {15'd0, s_busy}, 16'd0);
        chk({n, "_rden"}, {15'd0, s_rden}, 16'd0);
        chk({n, "_wren"}, {15'd0, s_wren}, 16'd0);
        chk({n, "_addr"}, s_addr, 16'd0);
        chk({n, "_data"}, {8'd0, s_data}, 16'd0);
        chk({n, "_reg"}, {13'd0, s_reg}, 16'd4);
    endtask

    task automatic xfer(input logic [7:0] pg, input logic par, input int div,
                        input int gap_at, input int abort_at, input int exp_ticks);
        bit done, gapd;
        int k;
        while (tb_par != par) cyc(1'b1);
        cur_page = pg; rd_cnt = 0; wr_cnt = 0; halt_ticks = 0;
        I_cpu_addr = 16'h4014; I_cpu_wren = 1'b1; I_cpu_data = pg;
        cyc(1'b1);
        cyc(div == 1);
        chk("halt_rise", {15'd0, s_halt}, 16'd1);
        chk("busy_rise", {15'd0, s_busy}, 16'd1);
        done = 1'b0; gapd = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            cyc((c % div) == 0);
            if (!s_halt) done = 1'b1;
            if (!gapd && gap_at >= 0 && wr_cnt == gap_at) begin
                gapd = 1'b1;
                repeat (50) cyc(1'b0);
                I_cpu_addr = 16'h4014; I_cpu_wren = 1'b1; I_cpu_data = 8'h07;
                cyc(1'b1);
            end
            if (abort_at >= 0 && wr_cnt == abort_at) begin
                I_reset = 1'b1;
                cyc(1'b1);
                I_reset = 1'b0;
                tb_par = 1'b0;
                cyc(1'b0);
                chk_idle("abort");
                k = rd_cnt;
                repeat (20) cyc(1'b1);
                chk("abort_no_rd", rd_cnt[15:0], k[15:0]);
                chk("abort_no_wr", wr_cnt[15:0], abort_at[15:0]);
                return;
            end
        end
        chk("xfer_done", {15'd0, done}, 16'd1);
        chk("halt_ticks", halt_ticks[15:0], exp_ticks[15:0]);
        chk("rd_count", rd_cnt[15:0], 16'd256);
        chk("wr_count", wr_cnt[15:0], 16'd256);
        chk("busy_fall", {15'd0, s_busy}, 16'd0);
    endtask

    initial begin
        vt[0] = '{t: 1'b1, w: 1'b1, a: 16'h4013, d: 8'h02, busy: 1'b0};
        vt[1] = '{t: 1'b1, w: 1'b1, a: 16'h4015, d: 8'h02, busy: 1'b0};
        vt[2] = '{t: 1'b1, w: 1'b0, a: 16'h4014, d: 8'h02, busy: 1'b0};
        vt[3] = '{t: 1'b0, w: 1'b1, a: 16'h4014, d: 8'h02, busy: 1'b0};
        vt[4] = '{t: 1'b1, w: 1'b1, a: 16'h4014, d: 8'h02, busy: 1'b1};
        I_reset = 1'b0; I_tick = 1'b0; I_cpu_wren = 1'b0; I_cpu_addr = 16'h0; I_cpu_data = 8'h0;
        tb_par = 1'b0; cur_page = 8'h0; rd_cnt = 0; wr_cnt = 0; halt_ticks = 0; last_rd = 16'h0;
        rst();
        cyc(1'b0);
        chk_idle("reset");
        cur_page = 8'h02;
        for (int i = 0; i < 5; i++) begin
            I_cpu_addr = vt[i].a; I_cpu_wren = vt[i].w; I_cpu_data = vt[i].d;
            cyc(vt[i].t);
            cyc(1'b0);
            chk($sformatf("vec%0d_busy", i), {15'd0, s_busy}, {15'd0, vt[i].busy});
            chk($sformatf("vec%0d_halt", i), {15'd0, s_halt}, {15'd0, vt[i].busy});
        end
        rst();
        xfer(8'h02, 1'b0, 1, -1, -1, 513);
        xfer(8'h02, 1'b1, 2, -1, -1, 514);
        xfer(8'hFF, 1'b0, 1, -1, -1, 513);
        chk("page_ff_last_rd", last_rd, 16'hFFFF);
        xfer(8'h02, 1'b0, 2, 100, -1, 513);
        xfer(8'h02, 1'b1, 1, -1, 100, 0);
        xfer(8'h03, 1'b0, 1, -1, -1, 513);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
